// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register slave: FSM encoding, header R/W
// flag values and the sample-edge polarity helper.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_WR      = 3'd2,
      ST_RD      = 3'd3,
      ST_DISCARD = 3'd4
   } spi_state_e;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // Modes 0 and 3 sample on the rising SCK edge, modes 1 and 2 on the falling one.
   function automatic logic sample_on_rise(input logic cpol, input logic cpha);
      return ~(cpol ^ cpha);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses. The level output
// appears STAGES cycles after the pin, the pulses one cycle later.
module spi_sync_edge #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   assign dout = sync[STAGES-1];

   // Shift the pin through the chain and flag level changes at its output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         prev <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         prev <= sync[STAGES-1];
         rise <= sync[STAGES-1] & ~prev;
         fall <= ~sync[STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave to register-bus bridge, all four SPI modes, optional burst.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | cs high (or not yet seen high after reset), edges ignored
// ST_HDR     | shifting in {rw, addr}
// ST_WR      | shifting in write words, one wr_en per completed word
// ST_RD      | shifting out read words, prefetching the next address
// ST_DISCARD | single-word frame done, remaining bits ignored
module spi_reg_slave
   import spi_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 3,
   parameter int RD_LAT      = 2,
   parameter int BURST_EN    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              frame_abort
);

   localparam int   HDR_W    = ADDR_W + 1;
   localparam int   MAXW     = (HDR_W > DATA_W) ? HDR_W : DATA_W;
   localparam int   CNT_W    = $clog2(MAXW + 1);
   localparam int   LAT_W    = $clog2(RD_LAT + 2);
   localparam logic SMP_RISE = sample_on_rise(CPOL != 0, CPHA != 0);

   spi_state_e         state, state_d;
   logic               cs_lvl, cs_rise, cs_fall;
   logic               sck_lvl_unused, sck_rise, sck_fall;
   logic [SYNC_STAGES:0] mosi_pipe;
   logic               mosi_s;
   logic               armed, active, smp, shf, last_bit, hdr_done, word_done;
   logic               load_pend;
   logic [CNT_W-1:0]   bit_cnt;
   logic [MAXW-2:0]    rx;
   logic [HDR_W-1:0]   hdr_word;
   logic [DATA_W-1:0]  data_word, tx, hold;
   logic [ADDR_W-1:0]  addr;
   logic [LAT_W-1:0]   lat_cnt;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .clk(clk), .rst_n(rst_n), .din(sck),
      .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .clk(clk), .rst_n(rst_n), .din(cs),
      .dout(cs_lvl), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi gets one extra stage so it lines up with the registered edge pulses;
   // armed blocks busy until cs has been seen high after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_pipe <= '0;
         armed     <= 1'b0;
      end else begin
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-1:0], mosi};
         armed     <= armed | cs_lvl;
      end
   end

   assign mosi_s    = mosi_pipe[SYNC_STAGES];
   assign active    = ~cs_lvl && (state != ST_IDLE);
   assign smp       = active && (SMP_RISE ? sck_rise : sck_fall);
   assign shf       = active && (SMP_RISE ? sck_fall : sck_rise);
   assign hdr_word  = {rx[HDR_W-2:0], mosi_s};
   assign data_word = {rx[DATA_W-2:0], mosi_s};
   assign last_bit  = (state == ST_HDR) ? (bit_cnt == CNT_W'(HDR_W - 1))
                                        : (bit_cnt == CNT_W'(DATA_W - 1));
   assign hdr_done  = smp && (state == ST_HDR) && last_bit;
   assign word_done = smp && ((state == ST_WR) || (state == ST_RD)) && last_bit;

   assign miso = (state == ST_RD) && ~cs_lvl && tx[DATA_W-1];
   assign busy = armed && ~cs_lvl;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Next-state decode; a cs rise always returns to idle.
   always_comb begin
      state_d = state;
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (cs_fall) state_d = ST_HDR;
            ST_HDR:  if (hdr_done)
                        state_d = (hdr_word[HDR_W-1] == RW_READ) ? ST_RD : ST_WR;
            ST_WR, ST_RD: if (word_done && (BURST_EN == 0)) state_d = ST_DISCARD;
            default: ;
         endcase
      end
   end

   // Shifters, bit counter, address tracking, bus strobes and read-latency timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         frame_abort <= 1'b0;
         bit_cnt     <= '0;
         rx          <= '0;
         tx          <= '0;
         hold        <= '0;
         addr        <= '0;
         lat_cnt     <= '0;
         load_pend   <= 1'b0;
      end else begin
         wr_en       <= 1'b0;
         rd_req      <= 1'b0;
         frame_abort <= 1'b0;
         if (lat_cnt != '0)          lat_cnt <= lat_cnt - LAT_W'(1);
         if (lat_cnt == LAT_W'(1))   hold    <= rd_data;
         if (cs_rise || cs_fall) begin
            frame_abort <= cs_rise && (state != ST_IDLE) && (bit_cnt != '0);
            bit_cnt     <= '0;
            rx          <= '0;
            tx          <= '0;
            load_pend   <= 1'b0;
            lat_cnt     <= '0;
            if (cs_fall) hold <= '0;
         end else begin
            if (smp) begin
               rx      <= {rx[MAXW-3:0], mosi_s};
               bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
               if (hdr_done) begin
                  addr <= hdr_word[ADDR_W-1:0];
                  if (hdr_word[HDR_W-1] == RW_READ) begin
                     rd_req    <= 1'b1;
                     rd_addr   <= hdr_word[ADDR_W-1:0];
                     lat_cnt   <= LAT_W'(RD_LAT + 1);
                     load_pend <= 1'b1;
                  end
               end
               if (word_done && (state == ST_WR)) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= data_word;
                  addr    <= addr + ADDR_W'(1);
               end
               if (word_done && (state == ST_RD) && (BURST_EN != 0)) begin
                  rd_req    <= 1'b1;
                  rd_addr   <= addr + ADDR_W'(1);
                  addr      <= addr + ADDR_W'(1);
                  lat_cnt   <= LAT_W'(RD_LAT + 1);
                  load_pend <= 1'b1;
               end
            end
            if (shf) begin
               if (load_pend) begin
                  tx        <= hold;
                  load_pend <= 1'b0;
               end else begin
                  tx <= {tx[DATA_W-2:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave to register-bus bridge, successor to the fixed 8-bit mode-0 slave. Supports all four CPOL/CPHA modes, configurable address and data widths, a read/write flag in the header, and auto-incrementing burst transfers. It sits between the off-chip SPI pins and the on-chip register file, entirely in the `clk` domain with oversampled SPI inputs.

## Interface
- `ADDR_W`, 7: register address width; header = 1 R/W bit + `ADDR_W` bits.
- `DATA_W`, 8: data word width.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `SYNC_STAGES`, 3: synchroniser depth on `sck`, `cs`, `mosi` (min 2).
- `RD_LAT`, 2: `clk` cycles from `rd_req` to valid `rd_data` (min 1).
- `BURST_EN`, 1: 1 = auto-increment across words; 0 = single word per frame.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cs` in 1: SPI chip select, active low.
- `sck` in 1: SPI clock.
- `mosi` in 1: master-out, slave-in.
- `miso` out 1: master-in, slave-out. 0 when cs high. No tristate.
- `wr_en` out 1: one-cycle register write strobe.
- `wr_addr` out `ADDR_W`: write address.
- `wr_data` out `DATA_W`: write data.
- `rd_req` out 1: one-cycle register read strobe.
- `rd_addr` out `ADDR_W`: read address.
- `rd_data` in `DATA_W`: read data, valid `RD_LAT` cycles after `rd_req`.
- `busy` out 1: high while a frame is active (synchronised cs low).
- `frame_abort` out 1: one-cycle pulse when cs rises mid-word.

## Operation
- Reset: all outputs and internal registers are 0, and the FSM is in IDLE.
- Edge polarity: the sample edge is rising when `CPOL^CPHA`=0 and falling otherwise. The shift edge is the opposite edge. Edges are ignored while synchronised cs is high.
- Frame format is MSB first. The header is `{rw, addr}`, with rw=1 meaning read. One or more `DATA_W` words follow.
- FSM states: IDLE, HDR, WR, RD, DISCARD.
  - IDLE→HDR on synchronised cs fall.
  - HDR→WR or HDR→RD after `ADDR_W`+1 sample edges.
  - WR/RD stay in place after each word if `BURST_EN`=1, else go to DISCARD.
  - Any state→IDLE on synchronised cs rise.
- Write path: at the sample edge completing a data word, assert `wr_en` with `wr_addr`=current address and `wr_data`=shifted word. The address then increments modulo 2^`ADDR_W`, so 0x7F wraps to 0x00.
- Read path:
  - At the sample edge completing the header, issue `rd_req` with `rd_addr`=addr.
  - Capture `rd_data` `RD_LAT` cycles later into a holding register.
  - Load the tx shifter at the next shift edge; `miso`=tx MSB.
  - In burst mode, at the sample edge completing each data word, issue `rd_req` for address+1 (wrapping). The result loads at the following shift edge.
  - `mosi` during a read data phase is shifted in and ignored.
- `miso` is 0 during the header, in DISCARD, and when cs is high.
- DISCARD: bits are counted and ignored. No `wr_en` and no `rd_req`.
- cs rise with a nonzero bit count in the current header or word:
  - pulse `frame_abort`;
  - discard the partial word, with no write;
  - clear the counter and shifters.
- cs fall in the same cycle as a pending `rd_data` capture: the capture is dropped and the new frame starts clean.

## Timing
- An SPI edge is detected `SYNC_STAGES`+1 `clk` cycles after the pin transition. `mosi` goes through the same synchroniser depth, so it is aligned with the edge.
- `wr_en` and `rd_req` are asserted one cycle after the detected sample edge.
- `miso` updates one cycle after the detected shift edge, i.e. `SYNC_STAGES`+2 cycles after the pin edge.
- Required SCK half-period is at least `SYNC_STAGES`+`RD_LAT`+4 `clk` cycles, which is 9 at defaults. Behaviour below this limit is unspecified.
- `busy` follows the synchronised cs with `SYNC_STAGES` cycles of latency.

## Structure
- Package `spi_pkg` holds:
  - the FSM state encoding (IDLE/HDR/WR/RD/DISCARD);
  - the R/W bit value constants;
  - a function for the sample-edge polarity from CPOL/CPHA.
- Sub-module `spi_sync_edge` (parameter `STAGES`): a synchroniser plus rise/fall pulse outputs. It is instantiated for `sck` and `cs`. `mosi` uses a plain synchroniser only.

## Test plan
- Mode 0, write header 0x05 (rw=0, addr 0x05) then data 0xA5 → exactly one `wr_en` with `wr_addr`=0x05, `wr_data`=0xA5, and `frame_abort`=0.
- Mode 3, read addr 0x10 with a model returning 0x3C after `RD_LAT`=2 → `rd_req` with `rd_addr`=0x10, and the master receives 0x3C MSB first.
- Mode 1, burst write starting at addr 0x7E with words 0x11, 0x22, 0x33 → writes to 0x7E, 0x7F, 0x00 in order.
- `BURST_EN`=0, mode 2 read of addr 0x02 sending 2 words → one `rd_req`; the second word on `miso` is 0x00.
- Drop cs after 5 bits of the first data word → `frame_abort` pulse and no `wr_en`. The next frame, writing 0x44 to addr 0x01, completes correctly.
- Assert `rst_n`=0 mid-read burst → all outputs are 0 immediately. After release with cs still low, no strobes occur until cs rises and falls again.
